img_conv3x3: RTL and testbench

IMG_CONV3X3 -- requirements
Module: img_conv3x3

---
 rtl/img_conv3x3.sv | 157 +++++++++++++++
 tb/tb_img_conv3x3.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/img_conv3x3.sv
// 3x3 Sobel / passthrough filter over a raster-order grayscale stream.
// Two line buffers feed a 3x3 window; a compute stage and an output stage
// give a fixed two-edge latency from the accepting edge to oDVAL.
// Optional build macro: CONV_THRESH_EN adds iTHRESH and binarises the
// gradient modes (01, 10, 11).
module img_conv3x3 #(
  parameter int PIX_W = 12,
  parameter int IMG_W = 640
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [PIX_W-1:0] iDATA,
  input  logic             iDVAL,
  input  logic             iSOF,
  input  logic [1:0]       iMODE,
`ifdef CONV_THRESH_EN
  input  logic [PIX_W-1:0] iTHRESH,
`endif
  output logic [PIX_W-1:0] oDATA,
  output logic             oDVAL
);

  localparam int CW = $clog2(IMG_W);
  localparam int SW = PIX_W + 4;
  localparam logic [PIX_W-1:0] MAXV = '1;

  // rowCnt saturates at 2: only "row >= 2" matters for output qualification
  logic [CW-1:0]    colCnt, colEff;
  logic [1:0]       rowCnt, rowEff;
  logic             frameOn;
  logic [1:0]       modeReg;
  logic [PIX_W-1:0] lineBuf0 [IMG_W];
  logic [PIX_W-1:0] lineBuf1 [IMG_W];
  logic [PIX_W-1:0] win [3][3];
  logic             v1, vA;
  logic [PIX_W-1:0] resA;
`ifdef CONV_THRESH_EN
  logic             passA;
`endif

  logic signed [SW-1:0] ext [3][3];
  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0]        absX, absY;
  logic [SW:0]          magWide;
  logic [PIX_W-1:0]     satV;

  // Position of the pixel being offered; an accepted iSOF forces (0,0)
  always_comb begin
    colEff = iSOF ? '0 : colCnt;
    rowEff = iSOF ? '0 : rowCnt;
  end

  // Column/row counters, frame-started flag and per-frame mode latch
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      colCnt  <= '0;
      rowCnt  <= '0;
      frameOn <= 1'b0;
      modeReg <= 2'b00;
    end else if (iDVAL) begin
      if (colEff == CW'(IMG_W - 1)) begin
        colCnt <= '0;
        rowCnt <= (rowEff == 2'd2) ? rowEff : rowEff + 2'd1;
      end else begin
        colCnt <= colEff + 1'b1;
        rowCnt <= rowEff;
      end
      if (iSOF) begin
        frameOn <= 1'b1;
        modeReg <= iMODE;
      end
    end
  end

  // Line buffers: lineBuf0 holds row-1, lineBuf1 holds row-2 at each column
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      lineBuf0[colEff] <= iDATA;
      lineBuf1[colEff] <= lineBuf0[colEff];
    end
  end

  // 3x3 window shifts left by one column per accepted pixel
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lineBuf1[colEff];
      win[1][2] <= lineBuf0[colEff];
      win[2][2] <= iDATA;
    end
  end

  // Window valid: only frames opened by iSOF, from row 2 / col 2 onwards
  always_ff @(posedge iCLK) begin
    if (!iRST) v1 <= 1'b0;
    else       v1 <= iDVAL && frameOn && (rowEff == 2'd2) && (colEff >= CW'(2));
  end

  // Sobel gradients, magnitudes, mode select and saturation
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        ext[r][c] = $signed({4'b0000, win[r][c]});
    gx = ext[0][2] + (ext[1][2] <<< 1) + ext[2][2]
       - ext[0][0] - (ext[1][0] <<< 1) - ext[2][0];
    gy = ext[2][0] + (ext[2][1] <<< 1) + ext[2][2]
       - ext[0][0] - (ext[0][1] <<< 1) - ext[0][2];
    absX = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    absY = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    magWide = '0;
    case (modeReg)
      2'b00:   magWide = {5'b00000, win[1][1]};
      2'b01:   magWide = {1'b0, absX};
      2'b10:   magWide = {1'b0, absY};
      default: magWide = {1'b0, absX} + {1'b0, absY};
    endcase
    satV = (magWide > {5'b00000, MAXV}) ? MAXV : magWide[PIX_W-1:0];
  end

  // Compute stage register; mode is captured here so a new frame's iSOF
  // cannot alter results still in flight
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      vA <= 1'b0;
    end else begin
      vA <= v1;
      if (v1) begin
        resA <= satV;
`ifdef CONV_THRESH_EN
        passA <= (modeReg == 2'b00);
`endif
      end
    end
  end

  // Output stage; oDATA holds between valid pulses
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      oDVAL <= 1'b0;
      oDATA <= '0;
    end else begin
      oDVAL <= vA;
      if (vA) begin
`ifdef CONV_THRESH_EN
        if (passA) oDATA <= resA;
        else       oDATA <= (resA >= iTHRESH) ? MAXV : '0;
`else
        oDATA <= resA;
`endif
      end
    end
  end

endmodule

// File: tb/tb_img_conv3x3.sv
// Directed bench for img_conv3x3 with PIX_W=12, IMG_W=8 and 8-row frames.
module tb_img_conv3x3;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [11:0] iDATA = '0;
  logic        iDVAL = 1'b0;
  logic        iSOF = 1'b0;
  logic [1:0]  iMODE = 2'b00;
  logic [11:0] oDATA;
  logic        oDVAL;
`ifdef CONV_THRESH_EN
  logic [11:0] iTHRESH = 12'd50;
`endif

  img_conv3x3 #(.PIX_W(12), .IMG_W(8)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF),
    .iMODE(iMODE),
`ifdef CONV_THRESH_EN
    .iTHRESH(iTHRESH),
`endif
    .oDATA(oDATA), .oDVAL(oDVAL)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int outCnt = 0;
  int expVal[$];
  int expCyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // pat 0: constant 100, pat 1: ramp 10*col, pat 2: vertical step at row 4
  function automatic int pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 100;
      1:       return 10 * c;
      default: return (r < 4) ? 0 : 4095;
    endcase
  endfunction

  // Hand-derived result for the window whose bottom-right is (r,c)
  function automatic int expOut(input int pat, input int mode, input int r, input int c);
    int cr = r - 1;
    int cc = c - 1;
    int raw;
    case (pat)
      0: raw = (mode == 0) ? 100 : 0;
      1: case (mode)
           0: raw = 10 * cc;
           2: raw = 0;
           default: raw = 80;
         endcase
      default: case (mode)
           0: raw = (cr < 4) ? 0 : 4095;
           1: raw = 0;
           default: raw = (cr == 3 || cr == 4) ? 4095 : 0;
         endcase
    endcase
`ifdef CONV_THRESH_EN
    if (mode != 0) raw = (raw >= 50) ? 4095 : 0;
`endif
    return raw;
  endfunction

  // Every output is matched in order against the expectation queue
  always @(negedge iCLK) begin
    if (oDVAL) begin
      outCnt++;
      if (expVal.size() == 0) begin
        chk("spurious_dval", oDVAL, 0);
      end else begin
        int v, cy;
        v  = expVal.pop_front();
        cy = expCyc.pop_front();
        chk("data", oDATA, v);
        chk("latency", cyc - cy, 2);
      end
    end
  end

  task automatic sendFrame(input int pat, input int modeStart, input int modeLate,
                           input int lateRow, input bit doSof, input int nPix,
                           input int gapMax);
    for (int idx = 0; idx < nPix; idx++) begin
      int r, c, g;
      r = idx / 8;
      c = idx % 8;
      g = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
      repeat (g) begin
        iDVAL = 1'b0;
        iSOF  = 1'($urandom_range(1, 0));
        @(posedge iCLK); #1;
      end
      iDATA = 12'(pix(pat, r, c));
      iDVAL = 1'b1;
      iSOF  = doSof && (idx == 0);
      iMODE = (r >= lateRow) ? 2'(modeLate) : 2'(modeStart);
      if (doSof && r >= 2 && c >= 2) begin
        expVal.push_back(expOut(pat, modeStart, r, c));
        expCyc.push_back(cyc + 1);
      end
      @(posedge iCLK); #1;
    end
    iDVAL = 1'b0;
    iSOF  = 1'b0;
  endtask

  task automatic frameCheck(input string tag, input int pat, input int mode,
                            input int modeLate, input int lateRow, input int gapMax);
    outCnt = 0;
    sendFrame(pat, mode, modeLate, lateRow, 1'b1, 64, gapMax);
    repeat (6) @(posedge iCLK);
    #1;
    chk({tag, "_count"}, outCnt, 36);
    chk({tag, "_pending"}, expVal.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    chk("reset_dval", oDVAL, 0);
    chk("reset_data", oDATA, 0);
    iRST = 1'b1;
    @(posedge iCLK); #1;

    frameCheck("const_m00", 0, 0, 0, 99, 0);
    frameCheck("const_m11", 0, 3, 3, 99, 0);
    frameCheck("ramp_m01", 1, 1, 1, 99, 0);
    frameCheck("ramp_m10", 1, 2, 2, 99, 0);
    frameCheck("ramp_m00", 1, 0, 0, 99, 0);
    frameCheck("step_m10", 2, 2, 2, 99, 0);
    frameCheck("step_m11", 2, 3, 3, 99, 0);
    frameCheck("ramp_gaps", 1, 1, 1, 99, 3);
    frameCheck("ramp00_gaps", 1, 0, 0, 99, 2);
    frameCheck("mode_hold", 1, 1, 2, 4, 0);
    frameCheck("mode_next", 1, 2, 2, 99, 0);
    chk("hold_data", oDATA, 0);

    // Reset in the middle of row 3 with outputs in flight
    sendFrame(1, 1, 1, 99, 1'b1, 28, 0);
    iRST = 1'b0;
    @(posedge iCLK);
    @(negedge iCLK);
    chk("rst_kill_dval", oDVAL, 0);
    chk("rst_kill_data", oDATA, 0);
    expVal.delete();
    expCyc.delete();
    iRST = 1'b1;
    @(posedge iCLK); #1;

    outCnt = 0;
    sendFrame(1, 1, 1, 99, 1'b0, 24, 0);
    repeat (6) @(posedge iCLK);
    #1;
    chk("nosof_count", outCnt, 0);

    frameCheck("after_rst", 1, 1, 1, 99, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
